// File: rtl/accum_drain_if.sv
// Downstream stream of quantized words leaving accum_drain.
interface accum_drain_if #(
    parameter int BATCH  = 32,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    // A word moves on out_valid & out_ready; the master holds out_data/out_addr
    // stable while out_valid=1 and out_ready=0, and never drops valid unaccepted.
    logic                    out_valid;
    logic                    out_ready;
    logic [BATCH*DATA_W-1:0] out_data;
    logic [ADDR_W-1:0]       out_addr;

    modport master (output out_valid, output out_data, output out_addr, input out_ready);
    modport slave  (input out_valid, input out_data, input out_addr, output out_ready);
endinterface

// File: rtl/accum_drain.sv
// Sweeps an accumulation-buffer range, rounds/shifts each lane and streams words out
// through a credit-limited FIFO. Define ACCUM_DRAIN_SAT_EN to clamp lanes instead of wrapping.
module accum_drain #(
    parameter int DEPTH  = 256,
    parameter int BATCH  = 32,
    parameter int RD_LAT = 3,
    parameter int DATA_W = 16,
    parameter int RES_W  = 32,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int SH_W   = $clog2(RES_W),
    parameter int FIFO_D = RD_LAT + 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      start_addr,
    input  logic [ADDR_W:0]        length,
    input  logic [SH_W-1:0]        shift,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_W-1:0]      rd_addr,
    input  logic [BATCH*RES_W-1:0] rd_data,
    output logic [1:0]             fsm_state,
    accum_drain_if.master          dn
);
    localparam int CW = $clog2(2 * FIFO_D + 2);
    localparam int PW = $clog2(FIFO_D);
    localparam int OW = BATCH * DATA_W;
    localparam logic [ADDR_W:0]     DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic signed [RES_W:0] SAT_MAX = {{(RES_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [RES_W:0] SAT_MIN = {{(RES_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_FLUSH = 2'd2, S_DONE = 2'd3} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, rd_addr_q;
    logic [ADDR_W:0]   rem_q;
    logic [SH_W-1:0]   shift_q;
    logic [RD_LAT-1:0] tag_v_q;
    logic [ADDR_W-1:0] tag_a_q [RD_LAT];
    logic              qv_q;
    logic [ADDR_W-1:0] qa_q;
    logic [OW-1:0]     qd_q, quant_w;
    logic [OW-1:0]     mem_d_q [FIFO_D];
    logic [ADDR_W-1:0] mem_a_q [FIFO_D];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     cnt_q, inflight, credit;
    logic              ov_q;
    logic [OW-1:0]     od_q;
    logic [ADDR_W-1:0] oa_q;
    logic              pop, issue, last_issue, pipe_empty;

    function automatic logic [DATA_W-1:0] quant_lane(input logic [RES_W-1:0] v,
                                                     input logic [SH_W-1:0]  sh);
        logic signed [RES_W:0] ext, rnd, r;
        ext = $signed({v[RES_W-1], v});
        rnd = '0;
        if (sh != '0) rnd[sh - 1'b1] = 1'b1;
        r = (ext + rnd) >>> sh;
`ifdef ACCUM_DRAIN_SAT_EN
        if (r > SAT_MAX) r = SAT_MAX;
        else if (r < SAT_MIN) r = SAT_MIN;
`endif
        return r[DATA_W-1:0];
    endfunction

    always_comb begin
        quant_w = '0;
        for (int l = 0; l < BATCH; l++)
            quant_w[l*DATA_W +: DATA_W] = quant_lane(rd_data[l*RES_W +: RES_W], shift_q);
    end

    // Credit counts every word between issue and the FIFO output register; a word
    // leaving the FIFO this cycle frees its slot in time for a new issue.
    always_comb begin
        inflight = CW'(qv_q);
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(tag_v_q[i]);
    end

    assign pop        = (cnt_q != '0) && (!ov_q || dn.out_ready);
    assign credit     = inflight + cnt_q - CW'(pop);
    assign issue      = (state_q == S_ISSUE) && (credit < CW'(FIFO_D));
    assign last_issue = issue && (rem_q == (ADDR_W+1)'(1));
    assign pipe_empty = (tag_v_q == '0) && !qv_q && (cnt_q == '0) && !ov_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ISSUE;
            S_ISSUE: if (last_issue) state_d = S_FLUSH;
            S_FLUSH: if (pipe_empty) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == S_ISSUE) || (state_q == S_FLUSH);
        done      = (state_q == S_DONE);
        fsm_state = state_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q    <= '0;
            rd_addr_q <= '0;
            rem_q     <= '0;
            shift_q   <= '0;
            tag_v_q   <= '0;
            for (int i = 0; i < RD_LAT; i++) tag_a_q[i] <= '0;
            qv_q      <= 1'b0;
            qa_q      <= '0;
            qd_q      <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            ov_q      <= 1'b0;
            od_q      <= '0;
            oa_q      <= '0;
        end else begin
            if (state_q == S_IDLE && start) begin
                addr_q  <= start_addr;
                rem_q   <= (length == '0) ? DEPTH_L : length;
                shift_q <= shift;
            end else if (issue) begin
                rd_addr_q <= addr_q;
                addr_q    <= (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
                rem_q     <= rem_q - 1'b1;
            end
            tag_v_q[0] <= issue;
            tag_a_q[0] <= addr_q;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v_q[i] <= tag_v_q[i-1];
                tag_a_q[i] <= tag_a_q[i-1];
            end
            qv_q <= tag_v_q[RD_LAT-1];
            if (tag_v_q[RD_LAT-1]) begin
                qd_q <= quant_w;
                qa_q <= tag_a_q[RD_LAT-1];
            end
            if (qv_q) wr_ptr_q <= (wr_ptr_q == PW'(FIFO_D - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= (rd_ptr_q == PW'(FIFO_D - 1)) ? '0 : rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + CW'(qv_q) - CW'(pop);
            if (pop) begin
                ov_q <= 1'b1;
                od_q <= mem_d_q[rd_ptr_q];
                oa_q <= mem_a_q[rd_ptr_q];
            end else if (dn.out_ready) begin
                ov_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (qv_q) begin
            mem_d_q[wr_ptr_q] <= qd_q;
            mem_a_q[wr_ptr_q] <= qa_q;
        end
    end

    assert property (@(posedge clk) disable iff (!rst) (inflight + cnt_q) <= CW'(FIFO_D));
    assert property (@(posedge clk) disable iff (!rst) !(qv_q && !pop && cnt_q == CW'(FIFO_D)));

    assign rd_addr      = rd_addr_q;
    assign dn.out_valid = ov_q;
    assign dn.out_data  = od_q;
    assign dn.out_addr  = oa_q;
endmodule
